kbd_num_entry: RTL and testbench
================================

Name: kbd_num_entry

Overview:
- Sits directly downstream of the PS/2 keyboard top block and consumes its `scancode` and `KeyPressed` pulse.
- Turns Set-2 make codes for the digit row into a decimal entry buffer that supports backspace, clear and Enter.
- On Enter, converts the BCD buffer to binary with a sequential multiply-add loop.
- Presents the result to the game/processor side through a valid/ack handshake.

Parameters:
- MAX_DIGITS, 4: maximum number of decimal digits held in the entry buffer.
- VAL_W, 14: width of the binary result. Must satisfy 10^MAX_DIGITS - 1 < 2^VAL_W.
- CNT_W, 3: width of `digit_count`. Must satisfy 2^CNT_W > MAX_DIGITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- scancode  in  8  last make code from the keyboard block; valid in the cycle `key_pressed` is high
- key_pressed  in  1  one-cycle pulse per key press
- num_ack  in  1  consumer accepts `num_value`; sampled on posedge clk while `num_valid` is high
- num_value  out  VAL_W  committed binary value
- num_valid  out  1  `num_value` is ready; held until accepted
- bcd_digits  out  4*MAX_DIGITS  live entry buffer for the 7-seg display; least-significant digit in [3:0]
- digit_count  out  CNT_W  number of digits currently entered
- busy  out  1  high in CONVERT and HOLD; keys are ignored while high
- entry_err  out  1  one-cycle pulse on a rejected key

Behaviour:
- Reset (asynchronous, rst=1) puts the block in state ENTRY and clears every output register:
  - `num_value`=0, `num_valid`=0, `bcd_digits`=0, `digit_count`=0, `busy`=0, `entry_err`=0.
- Key decode happens only in a cycle with `key_pressed`=1, and only in ENTRY:
  - Digits 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
  - 0x66 = Backspace, 0x76 = Esc, 0x5A = Enter.
  - All other codes are ignored with no error.
- ENTRY, digit key:
  - If `digit_count` < MAX_DIGITS: `bcd_digits` <= {bcd_digits[4*MAX_DIGITS-5:0], d} and `digit_count`++.
  - If the buffer is full: buffer unchanged and `entry_err` pulses.
  - Leading zeros are accepted.
- ENTRY, Backspace:
  - If `digit_count`>0: shift `bcd_digits` right one nibble (zero fill) and `digit_count`--.
  - If `digit_count`=0: no-op, no error.
- ENTRY, Esc: clear `bcd_digits` and `digit_count`.
- ENTRY, Enter:
  - If `digit_count`=0: `entry_err` pulses and the state stays ENTRY.
  - Otherwise: accumulator <= 0, index <= `digit_count`-1, state -> CONVERT.
- CONVERT:
  - Each edge: acc <= acc*10 + bcd_digits[index] (most-significant entered digit first), then index--.
  - Multiply is shift-add ((acc<<3)+(acc<<1)) truncated to VAL_W.
  - On the edge that consumes index 0: `num_value` <= result, `num_valid` <= 1, state -> HOLD.
  - With n = `digit_count`, `num_valid` rises exactly n cycles after the edge that sampled Enter.
- HOLD:
  - `num_valid` and `num_value` stay stable until num_ack=1 is sampled.
  - On that edge: `num_valid` <= 0, `bcd_digits` <= 0, `digit_count` <= 0, state -> ENTRY.
  - `num_value` keeps the last committed value until the next commit.
  - Ack and valid in the same cycle completes the transfer.
- `busy` = (state != ENTRY), registered with the state.
- `key_pressed` during CONVERT/HOLD is dropped: no buffer change, no `entry_err`.
- `num_ack` is ignored outside HOLD.
- `entry_err` is registered and high for exactly one cycle per rejected key.
- rst asserted mid-CONVERT or mid-HOLD aborts immediately to the reset state; no partial value is published.

Optional Feature:
- Macro: KBD_NUM_KEYPAD_EN.
- When defined, numeric-keypad make codes are also decoded as digits:
  - 0x70=0, 0x69=1, 0x72=2, 0x7A=3, 0x6B=4, 0x73=5, 0x74=6, 0x6C=7, 0x75=8, 0x7D=9.
  - Keypad Enter, which arrives as 0x5A, is handled as Enter.
- When not defined, those codes fall under "other codes" and are ignored with no error.

Test Plan:
- Keys 0x16, 0x1E, 0x26 then 0x5A -> `bcd_digits`[11:0]=0x123, `digit_count`=3; `num_valid`=1 exactly 3 cycles after the Enter edge with `num_value`=123, `busy`=1; assert `num_ack` 2 cycles later -> next cycle `num_valid`=0, `digit_count`=0, `busy`=0.
- Keys 9,9,9,9 then a 5th key 0x45 -> `entry_err` one-cycle pulse, buffer stays 0x9999; Enter -> `num_value`=9999 after 4 cycles.
- Keys 4,7, 0x66, 2 then Enter -> `num_value`=42; a separate Enter on an empty buffer -> `entry_err` pulse, `busy` stays 0.
- Keys 5,5, 0x76 -> `digit_count`=0, `bcd_digits`=0; key 0x1C ('A') -> no change, no `entry_err`.
- During HOLD, key 3 -> ignored; assert rst mid-CONVERT of "0 0 7" -> all outputs 0 and state ENTRY; rerun to `num_value`=7.
- With KBD_NUM_KEYPAD_EN: keypad 0x69, 0x70 then Enter -> `num_value`=10. Without the macro: the same keys give `digit_count`=0 and Enter gives an `entry_err` pulse.

Source files
------------

// File: rtl/kbd_num_entry_if.sv
// kbd_num_entry_if
// Groups the keyboard-side inputs and the consumer-side handshake of
// kbd_num_entry into one bundle.
//
// Signals:
//   scancode     8             make code, meaningful only while key_pressed=1
//   key_pressed  1             one-cycle pulse per key press
//   num_ack      1             consumer accepts num_value
//   num_value    VAL_W         committed binary value
//   num_valid    1             num_value is ready
//   bcd_digits   4*MAX_DIGITS  live entry buffer, least-significant digit in [3:0]
//   digit_count  CNT_W         digits currently entered
//   busy         1             block is converting or holding a result
//   entry_err    1             one-cycle pulse on a rejected key
//
// Handshake: num_valid rises with a new num_value and both stay stable
// until num_ack is sampled high on a rising clk edge while num_valid is
// high; that edge completes the transfer, including when num_ack was
// already high in the cycle num_valid rose. num_ack is ignored while
// num_valid is low.
//
// Modports: master = keyboard block + consumer, slave = kbd_num_entry.
interface kbd_num_entry_if #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int CNT_W      = 3
);
    logic [7:0]              scancode;
    logic                    key_pressed;
    logic                    num_ack;
    logic [VAL_W-1:0]        num_value;
    logic                    num_valid;
    logic [4*MAX_DIGITS-1:0] bcd_digits;
    logic [CNT_W-1:0]        digit_count;
    logic                    busy;
    logic                    entry_err;

    modport master (
        output scancode, key_pressed, num_ack,
        input  num_value, num_valid, bcd_digits, digit_count, busy, entry_err
    );

    modport slave (
        input  scancode, key_pressed, num_ack,
        output num_value, num_valid, bcd_digits, digit_count, busy, entry_err
    );
endinterface

// File: rtl/kbd_num_entry.sv
// kbd_num_entry
// Builds a decimal number from PS/2 Set-2 digit-row make codes (with
// backspace, Esc clear and Enter), converts the BCD buffer to binary with
// a sequential multiply-by-ten loop, and offers the result on a valid/ack
// handshake.
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-high
//   bus      kbd_num_entry_if.slave (scancode, key_pressed, num_ack in;
//            num_value, num_valid, bcd_digits, digit_count, busy,
//            entry_err out)
//   state_o  current FSM state (0=ENTRY, 1=CONVERT, 2=HOLD) for debug
//
// Optional feature: define KBD_NUM_KEYPAD_EN to also accept numeric-keypad
// make codes as digits (keypad Enter shares 0x5A with the main Enter).
module kbd_num_entry #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 14,
    parameter int CNT_W      = 3
) (
    input  logic                clk,
    input  logic                rst,
    kbd_num_entry_if.slave      bus,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [4*MAX_DIGITS-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [VAL_W-1:0]        acc_q, acc_d;
    logic [VAL_W-1:0]        val_q, val_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    // Returns {is_digit, digit}.
    function automatic logic [4:0] decode_digit(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h45: r = 5'h10;
            8'h16: r = 5'h11;
            8'h1E: r = 5'h12;
            8'h26: r = 5'h13;
            8'h25: r = 5'h14;
            8'h2E: r = 5'h15;
            8'h36: r = 5'h16;
            8'h3D: r = 5'h17;
            8'h3E: r = 5'h18;
            8'h46: r = 5'h19;
`ifdef KBD_NUM_KEYPAD_EN
            8'h70: r = 5'h10;
            8'h69: r = 5'h11;
            8'h72: r = 5'h12;
            8'h7A: r = 5'h13;
            8'h6B: r = 5'h14;
            8'h73: r = 5'h15;
            8'h74: r = 5'h16;
            8'h6C: r = 5'h17;
            8'h75: r = 5'h18;
            8'h7D: r = 5'h19;
`endif
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [4:0]       dec;
    logic [3:0]       cur_digit;
    logic [VAL_W-1:0] acc_next;

    always_comb begin
        dec = decode_digit(bus.scancode);

        // Digit selected by the conversion index; index counts down so the
        // most-significant entered digit is consumed first.
        cur_digit = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (idx_q == CNT_W'(i)) cur_digit = bcd_q[4*i +: 4];
        end
        // acc*10 as shift-add, truncated to VAL_W.
        acc_next = (acc_q << 3) + (acc_q << 1) + VAL_W'(cur_digit);
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        val_d   = val_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        case (state_q)
            ENTRY: begin
                if (bus.key_pressed) begin
                    if (dec[4]) begin
                        if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                            bcd_d = {bcd_q[4*MAX_DIGITS-5:0], dec[3:0]};
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.scancode == 8'h66) begin
                        if (cnt_q != '0) begin
                            bcd_d = {4'd0, bcd_q[4*MAX_DIGITS-1:4]};
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else if (bus.scancode == 8'h76) begin
                        bcd_d = '0;
                        cnt_d = '0;
                    end else if (bus.scancode == 8'h5A) begin
                        if (cnt_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d   = '0;
                            idx_d   = cnt_q - CNT_W'(1);
                            state_d = CONVERT;
                        end
                    end
                end
            end
            CONVERT: begin
                acc_d = acc_next;
                idx_d = idx_q - CNT_W'(1);
                if (idx_q == '0) begin
                    val_d   = acc_next;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.num_ack) begin
                    valid_d = 1'b0;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ENTRY;
                end
            end
            default: state_d = ENTRY;
        endcase

        busy_d = (state_d != ENTRY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENTRY;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            val_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.num_value   = val_q;
    assign bus.num_valid   = valid_q;
    assign bus.bcd_digits  = bcd_q;
    assign bus.digit_count = cnt_q;
    assign bus.busy        = busy_q;
    assign bus.entry_err   = err_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_kbd_num_entry.sv
module tb_kbd_num_entry;
    logic       clk;
    logic       rst;
    logic [1:0] state_o;
    int         checks;
    int         errors;

    kbd_num_entry_if #(.MAX_DIGITS(4), .VAL_W(14), .CNT_W(3)) bus ();

    kbd_num_entry #(.MAX_DIGITS(4), .VAL_W(14), .CNT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one key for exactly one rising edge; returns on the
    // following negedge so registered effects are visible.
    task automatic press(input logic [7:0] code);
        @(negedge clk);
        bus.scancode    = code;
        bus.key_pressed = 1'b1;
        @(negedge clk);
        bus.key_pressed = 1'b0;
        bus.scancode    = 8'h00;
    endtask

    task automatic ack();
        bus.num_ack = 1'b1;
        @(negedge clk);
        bus.num_ack = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.num_value !== 14'd0 || bus.num_valid !== 1'b0) begin errors++; $display("FAIL reset_value: value=%0d valid=%0b required 0/0", bus.num_value, bus.num_valid); end
        checks++; if (bus.bcd_digits !== 16'h0 || bus.digit_count !== 3'd0) begin errors++; $display("FAIL reset_buffer: bcd=%h cnt=%0d required 0000/0", bus.bcd_digits, bus.digit_count); end
        checks++; if (bus.busy !== 1'b0 || bus.entry_err !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL reset_ctrl: busy=%0b err=%0b state=%0d required 0/0/0", bus.busy, bus.entry_err, state_o); end
        rst = 1'b0;
        tick();
        checks++; if (state_o !== 2'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release: state=%0d busy=%0b required 0/0", state_o, bus.busy); end
    endtask

    task automatic test_basic_123();
        press(8'h16); press(8'h1E); press(8'h26);
        checks++; if (bus.bcd_digits[11:0] !== 12'h123 || bus.digit_count !== 3'd3) begin errors++; $display("FAIL basic_entry: bcd=%h cnt=%0d required 123/3", bus.bcd_digits[11:0], bus.digit_count); end
        press(8'h5A);
        checks++; if (bus.busy !== 1'b1 || bus.num_valid !== 1'b0 || state_o !== 2'd1) begin errors++; $display("FAIL basic_enter: busy=%0b valid=%0b state=%0d required 1/0/1", bus.busy, bus.num_valid, state_o); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (bus.num_valid !== (k == 3)) begin errors++; $display("FAIL basic_latency: cycle %0d valid=%0b required %0b", k, bus.num_valid, (k == 3)); end
        end
        checks++; if (bus.num_value !== 14'd123 || bus.busy !== 1'b1 || state_o !== 2'd2) begin errors++; $display("FAIL basic_value: value=%0d busy=%0b state=%0d required 123/1/2", bus.num_value, bus.busy, state_o); end
        tick(); tick();
        checks++; if (bus.num_valid !== 1'b1 || bus.num_value !== 14'd123) begin errors++; $display("FAIL basic_hold: valid=%0b value=%0d required 1/123", bus.num_valid, bus.num_value); end
        ack();
        checks++; if (bus.num_valid !== 1'b0 || bus.digit_count !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_ack: valid=%0b cnt=%0d busy=%0b required 0/0/0", bus.num_valid, bus.digit_count, bus.busy); end
        checks++; if (bus.bcd_digits !== 16'h0 || bus.num_value !== 14'd123) begin errors++; $display("FAIL basic_after_ack: bcd=%h value=%0d required 0000/123", bus.bcd_digits, bus.num_value); end
    endtask

    task automatic test_full_buffer();
        repeat (4) press(8'h46);
        checks++; if (bus.bcd_digits !== 16'h9999 || bus.digit_count !== 3'd4) begin errors++; $display("FAIL full_entry: bcd=%h cnt=%0d required 9999/4", bus.bcd_digits, bus.digit_count); end
        press(8'h45);
        checks++; if (bus.entry_err !== 1'b1 || bus.bcd_digits !== 16'h9999 || bus.digit_count !== 3'd4) begin errors++; $display("FAIL full_reject: err=%0b bcd=%h cnt=%0d required 1/9999/4", bus.entry_err, bus.bcd_digits, bus.digit_count); end
        tick();
        checks++; if (bus.entry_err !== 1'b0) begin errors++; $display("FAIL full_err_pulse: err=%0b required 0", bus.entry_err); end
        press(8'h5A);
        tick(); tick(); tick();
        checks++; if (bus.num_valid !== 1'b0) begin errors++; $display("FAIL full_early: valid=%0b required 0", bus.num_valid); end
        tick();
        checks++; if (bus.num_valid !== 1'b1 || bus.num_value !== 14'd9999) begin errors++; $display("FAIL full_value: valid=%0b value=%0d required 1/9999", bus.num_valid, bus.num_value); end
        ack();
    endtask

    task automatic test_backspace();
        press(8'h25); press(8'h3D); press(8'h66);
        checks++; if (bus.bcd_digits !== 16'h0004 || bus.digit_count !== 3'd1) begin errors++; $display("FAIL bs_shift: bcd=%h cnt=%0d required 0004/1", bus.bcd_digits, bus.digit_count); end
        press(8'h1E);
        checks++; if (bus.bcd_digits !== 16'h0042 || bus.digit_count !== 3'd2) begin errors++; $display("FAIL bs_entry: bcd=%h cnt=%0d required 0042/2", bus.bcd_digits, bus.digit_count); end
        press(8'h5A);
        tick(); tick();
        checks++; if (bus.num_valid !== 1'b1 || bus.num_value !== 14'd42) begin errors++; $display("FAIL bs_value: valid=%0b value=%0d required 1/42", bus.num_valid, bus.num_value); end
        ack();
        press(8'h5A);
        checks++; if (bus.entry_err !== 1'b1 || bus.busy !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL empty_enter: err=%0b busy=%0b state=%0d required 1/0/0", bus.entry_err, bus.busy, state_o); end
        tick();
        checks++; if (bus.entry_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL empty_enter_after: err=%0b busy=%0b required 0/0", bus.entry_err, bus.busy); end
        press(8'h66);
        checks++; if (bus.entry_err !== 1'b0 || bus.digit_count !== 3'd0) begin errors++; $display("FAIL bs_empty: err=%0b cnt=%0d required 0/0", bus.entry_err, bus.digit_count); end
    endtask

    task automatic test_esc_other();
        press(8'h2E); press(8'h2E);
        checks++; if (bus.bcd_digits !== 16'h0055 || bus.digit_count !== 3'd2) begin errors++; $display("FAIL esc_pre: bcd=%h cnt=%0d required 0055/2", bus.bcd_digits, bus.digit_count); end
        press(8'h76);
        checks++; if (bus.bcd_digits !== 16'h0 || bus.digit_count !== 3'd0) begin errors++; $display("FAIL esc_clear: bcd=%h cnt=%0d required 0000/0", bus.bcd_digits, bus.digit_count); end
        press(8'h36);
        press(8'h1C);
        checks++; if (bus.bcd_digits !== 16'h0006 || bus.digit_count !== 3'd1 || bus.entry_err !== 1'b0) begin errors++; $display("FAIL other_key: bcd=%h cnt=%0d err=%0b required 0006/1/0", bus.bcd_digits, bus.digit_count, bus.entry_err); end
        // Ack while in ENTRY must not disturb the buffer.
        ack();
        checks++; if (bus.digit_count !== 3'd1 || bus.num_valid !== 1'b0 || state_o !== 2'd0) begin errors++; $display("FAIL ack_outside: cnt=%0d valid=%0b state=%0d required 1/0/0", bus.digit_count, bus.num_valid, state_o); end
        press(8'h76);
    endtask

    task automatic test_hold_ignore();
        press(8'h26); press(8'h5A);
        tick();
        checks++; if (bus.num_valid !== 1'b1 || bus.num_value !== 14'd3) begin errors++; $display("FAIL hold_value: valid=%0b value=%0d required 1/3", bus.num_valid, bus.num_value); end
        press(8'h26);
        checks++; if (bus.digit_count !== 3'd1 || bus.bcd_digits !== 16'h0003 || bus.entry_err !== 1'b0) begin errors++; $display("FAIL hold_key: cnt=%0d bcd=%h err=%0b required 1/0003/0", bus.digit_count, bus.bcd_digits, bus.entry_err); end
        press(8'h5A);
        checks++; if (bus.entry_err !== 1'b0 || bus.num_valid !== 1'b1 || state_o !== 2'd2) begin errors++; $display("FAIL hold_enter: err=%0b valid=%0b state=%0d required 0/1/2", bus.entry_err, bus.num_valid, state_o); end
        ack();
    endtask

    task automatic test_reset_mid_convert();
        press(8'h45); press(8'h45); press(8'h3D); press(8'h5A);
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL mid_state: state=%0d required 1", state_o); end
        rst = 1'b1;
        #1;
        checks++; if (bus.num_value !== 14'd0 || bus.num_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_out: value=%0d valid=%0b busy=%0b required 0/0/0", bus.num_value, bus.num_valid, bus.busy); end
        checks++; if (bus.bcd_digits !== 16'h0 || bus.digit_count !== 3'd0 || state_o !== 2'd0) begin errors++; $display("FAIL mid_reset_buf: bcd=%h cnt=%0d state=%0d required 0000/0/0", bus.bcd_digits, bus.digit_count, state_o); end
        tick();
        rst = 1'b0;
        press(8'h45); press(8'h45); press(8'h3D); press(8'h5A);
        tick(); tick(); tick();
        checks++; if (bus.num_valid !== 1'b1 || bus.num_value !== 14'd7) begin errors++; $display("FAIL rerun_value: valid=%0b value=%0d required 1/7", bus.num_valid, bus.num_value); end
        ack();
    endtask

    task automatic test_keypad();
        press(8'h69); press(8'h70);
`ifdef KBD_NUM_KEYPAD_EN
        checks++; if (bus.bcd_digits !== 16'h0010 || bus.digit_count !== 3'd2) begin errors++; $display("FAIL keypad_entry: bcd=%h cnt=%0d required 0010/2", bus.bcd_digits, bus.digit_count); end
        press(8'h5A);
        tick(); tick();
        checks++; if (bus.num_valid !== 1'b1 || bus.num_value !== 14'd10) begin errors++; $display("FAIL keypad_value: valid=%0b value=%0d required 1/10", bus.num_valid, bus.num_value); end
        ack();
`else
        checks++; if (bus.digit_count !== 3'd0 || bus.entry_err !== 1'b0) begin errors++; $display("FAIL keypad_off: cnt=%0d err=%0b required 0/0", bus.digit_count, bus.entry_err); end
        press(8'h5A);
        checks++; if (bus.entry_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL keypad_off_enter: err=%0b busy=%0b required 1/0", bus.entry_err, bus.busy); end
`endif
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.scancode    = 8'h00;
        bus.key_pressed = 1'b0;
        bus.num_ack     = 1'b0;

        test_reset();
        test_basic_123();
        test_full_buffer();
        test_backspace();
        test_esc_other();
        test_hold_ignore();
        test_reset_mid_convert();
        test_keypad();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
